// File: rtl/apb_simple_master.sv
// APB requester: turns a valid/ready command port into APB SETUP/ACCESS transfers and returns one response per command.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES cycles without PREADY.
module apb_simple_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_psel_nxt;
  logic                    w_penable_nxt;
  logic                    w_cmd_ready;
  logic                    w_accept;
  logic                    w_done;
  logic                    w_timeout;

  logic                    r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] r_tcnt;

  // Wait-state counter; held at zero outside ACCESS so every transfer starts fresh.
  always_ff @(posedge PCLK) begin
    if (rst) begin
      r_tcnt <= {CW{1'b0}};
    end else if (r_state != ST_ACCESS) begin
      r_tcnt <= {CW{1'b0}};
    end else if (!PREADY) begin
      r_tcnt <= r_tcnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign w_timeout = (r_state == ST_ACCESS) && !PREADY &&
                     (r_tcnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // A completing ACCESS cycle can accept the next command directly (back-to-back).
  assign w_cmd_ready = !rst && !w_timeout &&
                       ((r_state == ST_IDLE) || ((r_state == ST_ACCESS) && PREADY));
  assign w_accept    = cmd_valid && w_cmd_ready;
  assign w_done      = (r_state == ST_ACCESS) && PREADY;

  // Next state plus the APB control levels that go with it.
  always_comb begin
    w_state_nxt   = r_state;
    w_psel_nxt    = 1'b0;
    w_penable_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_SETUP;
        else          w_state_nxt = ST_IDLE;
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_done) begin
          if (w_accept) w_state_nxt = ST_SETUP;
          else          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_psel_nxt    = (w_state_nxt != ST_IDLE);
    w_penable_nxt = (w_state_nxt == ST_ACCESS);
  end

  // State register with registered APB select/enable.
  always_ff @(posedge PCLK) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
    end
  end

  // Command capture and response generation.
  always_ff @(posedge PCLK) begin
    if (rst) begin
      r_pwrite    <= 1'b0;
      r_paddr     <= {ADDR_WIDTH{1'b0}};
      r_pwdata    <= {DATA_WIDTH{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_WIDTH{1'b0}};
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
      end
      r_rsp_valid <= w_done || w_timeout;
      if (w_done) begin
        r_rsp_err <= PSLVERR;
      end else if (w_timeout) begin
        r_rsp_err <= 1'b1;
      end
      if (w_done && !r_pwrite) begin
        r_rsp_rdata <= PRDATA;
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
